// File: rtl/foc_pkg.sv
// Shared FOC datapath constants, rotation-coefficient helper and the
// inverse-Clarke sequencer state encoding.
package foc_pkg;

    localparam int FOC_D_WIDTH = 18;
    localparam int FOC_Q_BITS  = 15;

    // round(sqrt(3)/2 * 2^q); evaluated at elaboration only
    function automatic int k_q(input int q);
        return $rtoi(0.8660254 * (2.0 ** q) + 0.5);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2
    } ic_state_e;

endpackage

// File: rtl/inv_clarke_if.sv
// Request/result bundle between an inverse-Clarke client and the converter.
interface inv_clarke_if #(
    parameter int D_WIDTH = foc_pkg::FOC_D_WIDTH
);
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic                      start;
    logic signed [D_WIDTH-1:0] a;
    logic signed [D_WIDTH-1:0] b;
    logic signed [D_WIDTH-1:0] c;
    logic                      done;
    logic                      busy;
    logic                      sat;

    modport master (output alpha, beta, start, input a, b, c, done, busy, sat);
    modport slave  (input alpha, beta, start, output a, b, c, done, busy, sat);
endinterface

// File: rtl/sat_narrow.sv
// Signed clamp from IN_W to OUT_W bits; ovf flags a clamped value.
module sat_narrow #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 18
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);
    localparam logic signed [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

    always_comb begin
        // in range iff every bit above the output sign bit copies the input sign
        ovf  = (din[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){din[IN_W-1]}});
        dout = din[OUT_W-1:0];
        if (ovf)
            dout = din[IN_W-1] ? MINV : MAXV;
    end
endmodule

// File: rtl/inv_clarke.sv
// Inverse Clarke transform (alpha/beta -> a/b/c), three-cycle sequenced,
// one shared multiplier, saturated outputs.
module inv_clarke
    import foc_pkg::*;
#(
    parameter int D_WIDTH = FOC_D_WIDTH,
    parameter int Q_BITS  = FOC_Q_BITS
) (
    input  logic         clk,
    input  logic         rstb,
    inv_clarke_if.slave  bus
);
    localparam int W  = D_WIDTH + 2;
    localparam int PW = 2 * D_WIDTH;
    localparam logic signed [D_WIDTH-1:0] KQ   = D_WIDTH'(k_q(Q_BITS));
    localparam logic signed [PW-1:0]      HALF = PW'(1) <<< (Q_BITS - 1);

    ic_state_e                 state;
    logic signed [D_WIDTH-1:0] alpha_r, beta_r;
    logic signed [W-1:0]       kb_r, nha_r;
    logic signed [D_WIDTH-1:0] a_r, b_r, c_r;
    logic                      done_r, sat_r;

    logic signed [PW-1:0]      prod;
    logic signed [W-1:0]       kb_next, nha_next;
    logic [2:0][W-1:0]         wide;
    logic [2:0][D_WIDTH-1:0]   narrow;
    logic [2:0]                ovf;

    assign prod     = PW'(beta_r) * PW'(KQ);
    assign kb_next  = W'((prod + HALF) >>> Q_BITS);
    // negate before halving so -alpha/2 floors toward -inf as a whole
    assign nha_next = (-W'(alpha_r)) >>> 1;

    assign wide[0] = W'(alpha_r);
    assign wide[1] = nha_r + kb_r;
    assign wide[2] = nha_r - kb_r;

    for (genvar i = 0; i < 3; i++) begin : g_sat
        sat_narrow #(.IN_W(W), .OUT_W(D_WIDTH)) u_sat (
            .din  (wide[i]),
            .dout (narrow[i]),
            .ovf  (ovf[i])
        );
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state   <= IDLE;
            alpha_r <= '0;
            beta_r  <= '0;
            kb_r    <= '0;
            nha_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            done_r  <= 1'b0;
            sat_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    alpha_r <= bus.alpha;
                    beta_r  <= bus.beta;
                    state   <= MUL;
                end
                MUL: begin
                    kb_r  <= kb_next;
                    nha_r <= nha_next;
                    state <= SUM;
                end
                SUM: begin
                    a_r    <= narrow[0];
                    b_r    <= narrow[1];
                    c_r    <= narrow[2];
                    sat_r  <= |ovf;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a    = a_r;
    assign bus.b    = b_r;
    assign bus.c    = c_r;
    assign bus.done = done_r;
    assign bus.sat  = sat_r;
    assign bus.busy = (state == MUL) || (state == SUM);
endmodule

// File: tb/tb_inv_clarke.sv
// Directed-vector and reference-model bench for inv_clarke.
module tb_inv_clarke;
    localparam int DW = 18;

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    inv_clarke_if #(.D_WIDTH(DW)) bus();

    inv_clarke #(.D_WIDTH(DW), .Q_BITS(15)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    typedef struct {
        int al; int be; int a; int b; int c; bit s;
    } vec_t;

    vec_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint clampv(input longint v, inout bit s);
        if (v > 131071)  begin s = 1'b1; return 131071;  end
        if (v < -131072) begin s = 1'b1; return -131072; end
        return v;
    endfunction

    task automatic ref_model(input int al, input int be,
                             output int ea, output int eb, output int ec, output bit es);
        longint nha, kb;
        bit s;
        s   = 1'b0;
        nha = fdiv(-longint'(al), 2);
        kb  = fdiv(longint'(be) * 28378 + 16384, 32768);
        ea  = int'(clampv(al, s));
        eb  = int'(clampv(nha + kb, s));
        ec  = int'(clampv(nha - kb, s));
        es  = s;
    endtask

    // drive one request, return cycles until done (10 = timed out)
    task automatic conv(input int al, input int be, output int lat);
        @(negedge clk);
        bus.alpha = DW'(al);
        bus.beta  = DW'(be);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_out(input string tag, input int ea, input int eb,
                           input int ec, input bit es);
        chk({tag, " a"},   bus.a,   ea);
        chk({tag, " b"},   bus.b,   eb);
        chk({tag, " c"},   bus.c,   ec);
        chk({tag, " sat"}, bus.sat, es);
    endtask

    initial begin
        int lat, ea, eb, ec, nd;
        bit es;
        logic signed [DW-1:0] ra, rb;
        int seq_al[6];
        int seq_be[6];

        tbl[0] = '{27427,   0,       27427,   -13714,  -13714,  1'b0};
        tbl[1] = '{0,       16384,   0,       14189,   -14189,  1'b0};
        tbl[2] = '{-131072, 131071,  -131072, 131071,  -47975,  1'b1};
        tbl[3] = '{-131072, -131072, -131072, -47976,  131071,  1'b1};
        tbl[4] = '{131071,  131071,  131071,  47975,   -131072, 1'b1};
        tbl[5] = '{131071,  0,       131071,  -65536,  -65536,  1'b0};
        tbl[6] = '{-1,      1,       -1,      1,       -1,      1'b0};
        tbl[7] = '{1,       -1,      1,       -2,      0,       1'b0};
        tbl[8] = '{0,       0,       0,       0,       0,       1'b0};
        tbl[9] = '{1000,    2000,    1000,    1232,    -2232,   1'b0};

        bus.alpha = '0;
        bus.beta  = '0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset a",    bus.a,    0);
        chk("reset b",    bus.b,    0);
        chk("reset c",    bus.c,    0);
        chk("reset done", bus.done, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset sat",  bus.sat,  0);
        rstb = 1'b0;

        for (int i = 0; i < 10; i++) begin
            conv(tbl[i].al, tbl[i].be, lat);
            chk($sformatf("vec%0d latency", i), lat, 3);
            chk_out($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s);
            @(negedge clk);
            chk($sformatf("vec%0d done pulse", i), bus.done, 0);
            chk($sformatf("vec%0d hold b", i), bus.b, tbl[i].b);
        end

        // start held six cycles: only cycles 0 and 3 are accepted
        seq_al = '{1000, 5, 7, -3000, 9, 11};
        seq_be = '{2000, 5, 7, 4000, 9, 11};
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (k == 3)      chk_out("b2b first", 1000, 1232, -2232, 1'b0);
                else if (k == 6) chk_out("b2b second", -3000, 4964, -1964, 1'b0);
                else             chk("b2b done timing", k, 3);
            end
            if (k < 6) begin
                bus.alpha = DW'(seq_al[k]);
                bus.beta  = DW'(seq_be[k]);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("b2b done count", nd, 2);

        // reset while in MUL
        @(negedge clk);
        bus.alpha = DW'(1000);
        bus.beta  = DW'(2000);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("pre-reset busy", bus.busy, 1);
        rstb = 1'b1;
        #1;
        chk_out("mid reset", 0, 0, 0, 1'b0);
        chk("mid reset busy", bus.busy, 0);
        chk("mid reset done", bus.done, 0);
        @(negedge clk);
        rstb = 1'b0;
        nd = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("post reset no done", nd, 0);
        conv(0, 16384, lat);
        chk("post reset latency", lat, 3);
        chk_out("post reset", 0, 14189, -14189, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            ref_model(int'(ra), int'(rb), ea, eb, ec, es);
            conv(int'(ra), int'(rb), lat);
            chk($sformatf("rnd%0d latency", i), lat, 3);
            chk_out($sformatf("rnd%0d", i), ea, eb, ec, es);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/inv_clarke.md
INV_CLARKE -- requirements
Module: inv_clarke

Interface
REQ-001 SHALL have parameter D_WIDTH, default 18, signed Q-format data width.
REQ-002 SHALL have parameter Q_BITS, default 15, fractional bits of all data ports.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstb  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port alpha  input  D_WIDTH signed  stationary-frame alpha component.
REQ-006 SHALL have port beta  input  D_WIDTH signed  stationary-frame beta component.
REQ-007 SHALL have port start  input  1  request; alpha/beta sampled on the edge where it is accepted.
REQ-008 SHALL have port a  output  D_WIDTH signed  phase-a result.
REQ-009 SHALL have port b  output  D_WIDTH signed  phase-b result.
REQ-010 SHALL have port c  output  D_WIDTH signed  phase-c result.
REQ-011 SHALL have port done  output  1  one-cycle pulse; a/b/c valid and held until the next done.
REQ-012 SHALL have port busy  output  1  high while a conversion is in flight (states MUL, SUM).
REQ-013 SHALL have port sat  output  1  set with done when any of a/b/c was clamped.

Function
REQ-014 SHALL compute a = alpha; b = -alpha/2 + K*beta; c = -alpha/2 - K*beta; K = sqrt(3)/2.
REQ-015 SHALL use constant K_Q = round(0.8660254 * 2^Q_BITS) (28378 at Q_BITS=15).
REQ-016 SHALL form K*beta as full 2*D_WIDTH signed product, add 2^(Q_BITS-1), arithmetic-shift right Q_BITS (round half up).
REQ-017 SHALL form alpha/2 as arithmetic shift right by 1 (floor toward -inf).
REQ-018 SHALL sum in D_WIDTH+2 bits and saturate each result to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
REQ-019 SHALL implement FSM states IDLE, MUL, SUM; reset state IDLE.
REQ-020 SHALL, in IDLE with start=1, register alpha/beta and go to MUL; start=0 stays IDLE.
REQ-021 SHALL, in MUL, register product and -alpha/2, go to SUM unconditionally.
REQ-022 SHALL, in SUM, register saturated a/b/c and sat, assert done for the next cycle, go to IDLE.
REQ-023 SHALL give latency: done high in the third cycle after the accepting edge; throughput one result per 3 cycles.
REQ-024 SHALL ignore start while busy=1; no queuing, no corruption of in-flight data.
REQ-025 SHALL accept start in the cycle done is high (back-to-back without idle gap).
REQ-026 SHALL hold a/b/c/sat stable between done pulses; sat reflects only the latest result.

Reset
REQ-027 SHALL, on rstb=1 at any time including mid-conversion, force IDLE and a=b=c=0, done=0, busy=0, sat=0 immediately.
REQ-028 SHALL discard any in-flight conversion on reset; first start after rstb release is accepted normally.

Structure
REQ-029 SHALL take D_WIDTH/Q_BITS defaults, K_Q derivation and FSM state enum from shared package foc_pkg.
REQ-030 SHALL instantiate one sub-module sat_narrow (D_WIDTH+2 to D_WIDTH clamp with overflow flag), three copies.
REQ-031 SHALL use exactly one multiplier; no division.

Verification
REQ-032 alpha=27427, beta=0, start 1 cycle -> done after 3 cycles; a=27427, b=-13714, c=-13714, sat=0.
REQ-033 alpha=0, beta=16384 -> a=0, b=14189, c=-14189, sat=0.
REQ-034 alpha=-131072, beta=131071 -> a=-131072, b=131071 (clamped), c=-47975, sat=1.
REQ-035 start held high 6 cycles with new inputs each cycle -> exactly two done pulses, results for vectors sampled at cycles 0 and 3 only.
REQ-036 rstb pulsed during MUL -> outputs 0, busy 0, no done; next start yields correct result.
REQ-037 random alpha/beta in full range vs. bit-exact reference model -> all a/b/c/sat match.
